mem_port_arbiter: RTL and testbench

// Shares the single unified memory port of the ARM core between instruction fetch (IF) and data load/store (DM).
// - Serialises both requesters onto one req/ready memory interface.
// - Returns read data with a one-cycle ack.
// - Drives a stall to the core while any request is outstanding.
// - Guards against fetch starvation and against memory hang (timeout).

---
 rtl/arm_mem_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter_wdog.sv | 37 +++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arm_mem_pkg : shared types/constants for the unified memory port. Rev 1.0
// ----------------------------------------------------------------------------
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } memarb_state_t;

    localparam logic [31:0] ABORT_RDATA = 32'h0;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter_if : core-side and memory-side bus of the arbiter. Rev 1.0
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_ack;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;
    logic          dm_ack;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ready;

    logic          stall;
    logic          timeout_err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
               stall, timeout_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
               stall, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_wdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_wdog : 8-bit stall watchdog; expires on the limit-th enabled cycle. Rev 1.0
// ----------------------------------------------------------------------------
module mem_wdog (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] limit_i,
    output logic       expire_o
);
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables the watchdog entirely.
    assign expire_o = en_i && (limit_i != 8'd0) && (cnt_q == limit_i - 8'd1);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter : serialises fetch and data requests onto one memory port. Rev 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int AW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_CYC);

    memarb_state_t state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          if_ack_q, if_ack_d;
    logic          dm_ack_q, dm_ack_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          terr_q, terr_d;
    logic [3:0]    starve_q, starve_d;

    logic          if_elig, dm_elig;
    logic          wdog_clr, wdog_en, wdog_expire;
    logic [31:0]   done_rdata;

    // The requester being acked still holds its old req this cycle.
    assign if_elig    = bus.if_req && !if_ack_q;
    assign dm_elig    = bus.dm_req && !dm_ack_q;
    assign wdog_en    = (state_q != IDLE) && !bus.mem_ready;
    assign done_rdata = (!bus.mem_ready || mem_we_q) ? ABORT_RDATA : bus.mem_rdata;

    mem_wdog u_wdog (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (wdog_clr),
        .en_i     (wdog_en),
        .limit_i  (WDOG_LIMIT),
        .expire_o (wdog_expire)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        terr_d      = terr_q;
        starve_d    = starve_q;
        wdog_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (dm_elig && !(bus.if_req && (starve_q == STARVE_MAX))) begin
                    state_d     = DBUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    wdog_clr    = 1'b1;
                    if (!bus.if_req) begin
                        starve_d = 4'd0;
                    end else if (starve_q != 4'hF) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (if_elig) begin
                    state_d     = IBUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = 32'h0;
                    wdog_clr    = 1'b1;
                    starve_d    = 4'd0;
                end
            end
            IBUSY, DBUSY: begin
                if (bus.mem_ready || wdog_expire) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == IBUSY) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = done_rdata;
                    end else begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = done_rdata;
                    end
                end
                if (wdog_expire) begin
                    terr_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= 32'h0;
            dm_rdata_q  <= 32'h0;
            terr_q      <= 1'b0;
            starve_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            terr_q      <= terr_d;
            starve_q    <= starve_d;
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.if_ack      = if_ack_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.dm_ack      = dm_ack_q;
    assign bus.dm_rdata    = dm_rdata_q;
    assign bus.timeout_err = terr_q;
    assign bus.stall       = (bus.if_req && !if_ack_q) || (bus.dm_req && !dm_ack_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter : directed + randomized check against a transaction model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int SL = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mem_port_arbiter_if #(.AW(AW)) bus ();

    mem_port_arbiter #(
        .AW           (AW),
        .STARVE_LIMIT (SL),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Transaction-level model: who owns the port, how long it has waited.
    int          m_owner;   // 0 none, 1 fetch, 2 data
    bit          m_we;
    logic [31:0] m_addr, m_wdata;
    int          m_wait, m_starve;
    bit          m_ifack, m_dmack, m_terr;
    logic [31:0] m_ifrd, m_dmrd;
    int          grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_wait = 0; m_starve = 0;
        m_ifack = 0; m_dmack = 0; m_terr = 0; m_ifrd = 0; m_dmrd = 0;
    endtask

    task automatic finish_txn(input logic [31:0] rd);
        if (m_owner == 1) begin m_ifack = 1; m_ifrd = rd; end
        else              begin m_dmack = 1; m_dmrd = rd; end
        m_owner = 0;
    endtask

    // Predict the effect of the coming edge from the current inputs, then compare.
    task automatic tick();
        bit ie, de;
        ie = bus.if_req && !m_ifack;
        de = bus.dm_req && !m_dmack;
        m_ifack = 0;
        m_dmack = 0;
        if (m_owner != 0) begin
            if (bus.mem_ready) begin
                finish_txn((m_owner == 2 && m_we) ? 32'h0 : bus.mem_rdata);
            end else begin
                m_wait++;
                if (TO != 0 && m_wait == TO) begin
                    finish_txn(32'h0);
                    m_terr = 1;
                end
            end
        end else if (de && !(bus.if_req && m_starve == SL)) begin
            m_owner = 2; m_we = bus.dm_we; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
            m_wait = 0;
            m_starve = bus.if_req ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
            grants.push_back(2);
        end else if (ie) begin
            m_owner = 1; m_we = 0; m_addr = bus.if_addr; m_wait = 0; m_starve = 0;
            grants.push_back(1);
        end
        @(posedge clk);
        #1;
        chk("mem_req", bus.mem_req, m_owner != 0);
        if (m_owner != 0) begin
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_we", bus.mem_we, m_we);
            if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
        end
        chk("if_ack", bus.if_ack, m_ifack);
        chk("dm_ack", bus.dm_ack, m_dmack);
        if (m_ifack) chk("if_rdata", bus.if_rdata, m_ifrd);
        if (m_dmack) chk("dm_rdata", bus.dm_rdata, m_dmrd);
        chk("timeout_err", bus.timeout_err, m_terr);
        chk("stall", bus.stall, (bus.if_req && !m_ifack) || (bus.dm_req && !m_dmack));
        chk("ack_excl", bus.if_ack & bus.dm_ack, 1'b0);
    endtask

    initial begin
        int exp_order[6] = '{2, 2, 1, 2, 2, 1};
        bit if_done, dm_done;
        bit seen;

        reset = 1'b1;
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_if_ack", bus.if_ack, 1'b0);
        chk("rst_dm_ack", bus.dm_ack, 1'b0);
        chk("rst_terr", bus.timeout_err, 1'b0);
        reset = 1'b0;

        // Fetch only, memory answers in the first busy cycle.
        bus.if_req = 1; bus.if_addr = 32'h0; bus.mem_ready = 1; bus.mem_rdata = 32'hE3A00005;
        tick();
        chk("t1_memreq_n1", bus.mem_req, 1'b1);
        tick();
        chk("t1_ifack_n2", bus.if_ack, 1'b1);
        chk("t1_ifrdata", bus.if_rdata, 32'hE3A00005);
        tick();
        bus.if_req = 0;

        // Simultaneous requests: data first, then fetch after a one-cycle gap.
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h40;
        bus.if_req = 1; bus.if_addr = 32'h04; bus.mem_rdata = 32'h12345678;
        tick();
        chk("t2_dm_first", bus.mem_addr, 32'h40);
        tick();
        chk("t2_dm_ack", bus.dm_ack, 1'b1);
        chk("t2_dm_rdata", bus.dm_rdata, 32'h12345678);
        chk("t2_gap", bus.mem_req, 1'b0);
        bus.mem_rdata = 32'hE1A00000;
        tick();
        chk("t2_if_next", bus.mem_req, 1'b1);
        chk("t2_if_addr", bus.mem_addr, 32'h04);
        bus.dm_req = 0;
        tick();
        chk("t2_if_ack", bus.if_ack, 1'b1);
        tick();
        bus.if_req = 0;

        // Starvation guard: fetch steps aside only during data-ack cycles.
        grants.delete();
        bus.dm_req = 1; bus.dm_addr = 32'h500; bus.if_req = 1; bus.if_addr = 32'h600;
        for (int c = 0; c < 60 && grants.size() < 6; c++) begin
            bus.if_req = !m_dmack;
            tick();
        end
        chk("t3_grant_cnt", grants.size(), 6);
        for (int i = 0; i < 6 && i < grants.size(); i++) chk("t3_order", grants[i], exp_order[i]);
        bus.dm_req = 0; bus.if_req = 1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin tick(); seen = m_ifack; end
        chk("t3_if_done", seen, 1'b1);
        tick();
        bus.if_req = 0;

        // Store with memory ready delayed three cycles.
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h80; bus.dm_wdata = 32'hCAFEF00D;
        bus.mem_ready = 0; bus.mem_rdata = 32'hDEADBEEF;
        tick();
        for (int b = 0; b < 4; b++) begin
            chk("t4_we", bus.mem_we, 1'b1);
            chk("t4_addr", bus.mem_addr, 32'h80);
            chk("t4_wdata", bus.mem_wdata, 32'hCAFEF00D);
            chk("t4_stall", bus.stall, 1'b1);
            if (b == 3) bus.mem_ready = 1;
            tick();
        end
        chk("t4_dm_ack", bus.dm_ack, 1'b1);
        chk("t4_store_rdata", bus.dm_rdata, 32'h0);
        tick();
        bus.dm_req = 0; bus.dm_we = 0;

        // Memory hangs: abort eight cycles after the grant edge.
        bus.mem_ready = 0; bus.if_req = 1; bus.if_addr = 32'h100;
        tick();
        for (int w = 0; w < 7; w++) begin
            tick();
            chk("t5_no_early_ack", bus.if_ack, 1'b0);
        end
        tick();
        chk("t5_abort_ack", bus.if_ack, 1'b1);
        chk("t5_abort_rdata", bus.if_rdata, 32'h0);
        chk("t5_terr", bus.timeout_err, 1'b1);
        tick();
        bus.if_req = 0;
        bus.mem_ready = 1; bus.mem_rdata = 32'h55AA55AA;
        bus.dm_req = 1; bus.dm_addr = 32'h200;
        tick(); tick();
        chk("t5_next_ack", bus.dm_ack, 1'b1);
        chk("t5_terr_sticky", bus.timeout_err, 1'b1);
        tick();
        bus.dm_req = 0;

        // Reset two cycles into a data transaction.
        bus.mem_ready = 0; bus.dm_req = 1; bus.dm_addr = 32'h300;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        chk("t6_memreq_async", bus.mem_req, 1'b0);
        chk("t6_no_ack", bus.dm_ack, 1'b0);
        chk("t6_terr_clr", bus.timeout_err, 1'b0);
        model_reset();
        bus.dm_req = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t6_idle", bus.mem_req, 1'b0);
        chk("t6_no_ack_after", bus.dm_ack, 1'b0);

        // Randomized traffic; each requester holds its request through its ack cycle.
        if_done = 0; dm_done = 0;
        for (int c = 0; c < 600; c++) begin
            if (if_done) begin
                if_done = 0;
                bus.if_req = 1'($urandom_range(0, 1));
                bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end else if (m_ifack) begin
                if_done = 1;
            end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req = 1;
                bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (dm_done) begin
                dm_done = 0;
                bus.dm_req = 1'($urandom_range(0, 1));
                bus.dm_we = 1'($urandom_range(0, 1));
                bus.dm_addr = $urandom;
                bus.dm_wdata = $urandom;
            end else if (m_dmack) begin
                dm_done = 1;
            end else if (!bus.dm_req && $urandom_range(0, 1) == 0) begin
                bus.dm_req = 1;
                bus.dm_we = 1'($urandom_range(0, 1));
                bus.dm_addr = $urandom;
                bus.dm_wdata = $urandom;
            end
            bus.mem_ready = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
